snax_dream_out_buffer: RTL and testbench
========================================

SNAX_DREAM_OUT_BUFFER -- requirements
Module: snax_dream_out_buffer

Interface
REQ-001: Parameter DataWidth, default 512, SHALL set the result beat width in bits.
REQ-002: Parameter Depth, default 4, SHALL set the FIFO depth in beats; it SHALL be a power of two and at least 2.
REQ-003: Parameter RegDataWidth, default 32, SHALL set the width of the CSR-facing target and count fields.
REQ-004: clk_i  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005: rst_ni  in  1  SHALL be an asynchronous, active-low reset.
REQ-006: acc_data_i  in  DataWidth  SHALL carry the result beat from the accelerator.
REQ-007: acc_valid_i  in  1  SHALL mark acc_data_i valid.
REQ-008: acc_ready_o  out  1  SHALL indicate that the block accepts the beat.
REQ-009: stream_data_o  out  DataWidth  SHALL carry the head FIFO beat to the streamer.
REQ-010: stream_valid_o  out  1  SHALL mark stream_data_o valid.
REQ-011: stream_ready_i  in  1  SHALL indicate that the streamer takes the beat.
REQ-012: beat_target_i  in  RegDataWidth  SHALL give the number of beats per job, sampled on start.
REQ-013: start_i  in  1  SHALL be a single-cycle job start from CSR control.
REQ-014: clear_i  in  1  SHALL be a synchronous flush.
REQ-015: busy_o  out  1  SHALL be high in RUN or DRAIN.
REQ-016: done_o  out  1  SHALL be a one-cycle job-complete pulse.
REQ-017: beat_count_o  out  RegDataWidth  SHALL report the beats delivered downstream in the current or last job.

Function
REQ-018: The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-019: In IDLE, start_i=1 SHALL latch beat_target_i, zero the in-count and beat_count_o, and go to RUN; if the target is 0 it SHALL go directly to DONE.
REQ-020: start_i SHALL be ignored in RUN, DRAIN and DONE.
REQ-021: acc_ready_o SHALL equal (state==RUN) AND (FIFO not full); a push SHALL occur when acc_valid_i and acc_ready_o are both high.
REQ-022: Each push SHALL increment the in-count; the push that makes the in-count equal the target SHALL move the FSM to DRAIN on the same edge.
REQ-023: stream_valid_o SHALL equal (FIFO not empty); a pop SHALL occur when stream_valid_o and stream_ready_i are both high, and each pop SHALL increment beat_count_o.
REQ-024: Latency SHALL be 1 cycle: a beat pushed at edge N SHALL be visible on stream_data_o with stream_valid_o=1 after edge N.
REQ-025: The FIFO SHALL preserve order.
REQ-026: stream_data_o SHALL remain stable while stream_valid_o=1 and stream_ready_i=0.
REQ-027: A push and a pop in the same cycle SHALL leave the occupancy unchanged and SHALL be legal at any non-full occupancy; when the FIFO is full, no push SHALL occur even if a pop occurs.
REQ-028: The read and write pointers SHALL wrap modulo Depth; occupancy SHALL use log2(Depth)+1 bits so that full and empty are unambiguous.
REQ-029: In DRAIN, acc_ready_o SHALL be 0; the FSM SHALL go to DONE when the FIFO is empty (including on the cycle its last pop completes).
REQ-030: DONE SHALL last exactly one cycle with done_o=1 and SHALL then return to IDLE; beat_count_o SHALL hold until the next start.
REQ-031: clear_i=1 SHALL take priority over all other inputs: the FSM goes to IDLE, pointers, occupancy, in-count and beat_count_o go to 0, and no done_o pulse is produced.
REQ-032: The in-count and beat_count_o SHALL never exceed the latched target.

Reset
REQ-033: While rst_ni=0, the FSM SHALL be IDLE, pointers and counts SHALL be 0, and acc_ready_o, stream_valid_o, busy_o and done_o SHALL be 0; stream_data_o SHALL be 0.
REQ-034: Reset asserted mid-job SHALL discard all buffered beats with no done_o; after release the block SHALL accept a new start on the first edge.

Verification
REQ-035: target=3, source always valid, sink always ready -> 3 beats out in order, 1-cycle latency, done_o one cycle after last pop, beat_count_o=3.
REQ-036: target=8, Depth=4, stream_ready_i=0 -> acc_ready_o drops after 4 pushes and stream_data_o holds; release the sink -> all 8 beats delivered, done_o once.
REQ-037: target=0 start -> done_o 1 cycle after start; acc_ready_o stays 0; beat_count_o=0.
REQ-038: Simultaneous push/pop at occupancy 2 for 10 cycles -> occupancy stays 2 and pointers wrap with no loss or duplication.
REQ-039: clear_i asserted in DRAIN with 2 beats buffered -> next cycle IDLE, stream_valid_o=0, beat_count_o=0, no done_o.
REQ-040: rst_ni pulsed low mid-RUN, then start with target=2 -> clean 2-beat job and done_o.

Source files
------------

// File: rtl/snax_dream_out_buffer.sv
// Result buffer between the accelerator and the streamer; counts one job of beats and pulses done.
// Latency 1 cycle push-to-stream; acc_ready_o drops when the FIFO is full or outside RUN.

module snax_dream_out_fifo #(
    parameter int DataWidth = 512,
    parameter int Depth     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DataWidth-1:0]         wdata,
    output logic [DataWidth-1:0]         rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(Depth):0]       occupancy
);
    localparam int AddrWidth = $clog2(Depth);

    logic [DataWidth-1:0] mem [Depth];
    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth:0]   occ;
    logic                 do_push;
    logic                 do_pop;

    assign full      = (occ == (AddrWidth+1)'(Depth));
    assign empty     = (occ == '0);
    assign occupancy = occ;
    assign rdata     = mem[rd_ptr];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

module snax_dream_out_buffer #(
    parameter int DataWidth    = 512,
    parameter int Depth        = 4,
    parameter int RegDataWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DataWidth-1:0]    acc_data_i,
    input  logic                    acc_valid_i,
    output logic                    acc_ready_o,
    output logic [DataWidth-1:0]    stream_data_o,
    output logic                    stream_valid_o,
    input  logic                    stream_ready_i,
    input  logic [RegDataWidth-1:0] beat_target_i,
    input  logic                    start_i,
    input  logic                    clear_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [RegDataWidth-1:0] beat_count_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [RegDataWidth-1:0] target_q;
    logic [RegDataWidth-1:0] in_cnt_q;
    logic [RegDataWidth-1:0] beat_cnt_q;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(Depth):0]  fifo_occ;
    logic                    push;
    logic                    pop;
    logic                    last_push;

    assign acc_ready_o    = (state_q == RUN) && !fifo_full;
    assign stream_valid_o = !fifo_empty;
    assign push           = acc_valid_i && acc_ready_o;
    assign pop            = stream_valid_o && stream_ready_i;
    assign last_push      = push && ((in_cnt_q + 1'b1) == target_q);
    assign busy_o         = (state_q == RUN) || (state_q == DRAIN);
    assign done_o         = (state_q == DONE);
    assign beat_count_o   = beat_cnt_q;

    snax_dream_out_fifo #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .push      (push),
        .pop       (pop),
        .wdata     (acc_data_i),
        .rdata     (stream_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (fifo_occ)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (beat_target_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_push) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave on the edge that pops the final beat, not one cycle later.
                if (fifo_empty || (pop && (fifo_occ == 1))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            target_q   <= '0;
            in_cnt_q   <= '0;
            beat_cnt_q <= '0;
        end else if (clear_i) begin
            in_cnt_q   <= '0;
            beat_cnt_q <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            target_q   <= beat_target_i;
            in_cnt_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (push) begin
                in_cnt_q <= in_cnt_q + 1'b1;
            end
            if (pop) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_snax_dream_out_buffer.sv
// Directed bench for snax_dream_out_buffer: cycle table plus hand-written multi-cycle sequences.
module tb_snax_dream_out_buffer;
    localparam int DW = 32;
    localparam int RW = 32;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] acc_data;
    logic          acc_valid;
    logic          acc_ready;
    logic [DW-1:0] stream_data;
    logic          stream_valid;
    logic          stream_ready;
    logic [RW-1:0] beat_target;
    logic          start;
    logic          clear;
    logic          busy;
    logic          done;
    logic [RW-1:0] beat_count;

    int checks   = 0;
    int failures = 0;
    int push_n, pop_n, done_n;
    logic [DW-1:0] base;

    snax_dream_out_buffer #(.DataWidth(DW), .Depth(4), .RegDataWidth(RW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .acc_data_i     (acc_data),
        .acc_valid_i    (acc_valid),
        .acc_ready_o    (acc_ready),
        .stream_data_o  (stream_data),
        .stream_valid_o (stream_valid),
        .stream_ready_i (stream_ready),
        .beat_target_i  (beat_target),
        .start_i        (start),
        .clear_i        (clear),
        .busy_o         (busy),
        .done_o         (done),
        .beat_count_o   (beat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [RW-1:0] tgt;
        logic          valid;
        logic [DW-1:0] data;
        logic          rdy;
        logic          e_ar;
        logic          e_sv;
        logic          chk_dat;
        logic [DW-1:0] e_dat;
        logic          e_busy;
        logic          e_done;
        logic [RW-1:0] e_cnt;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(input logic st, input logic [RW-1:0] tg, input logic v,
                                input logic [DW-1:0] d, input logic r, input logic ar,
                                input logic sv, input logic cd, input logic [DW-1:0] ed,
                                input logic bz, input logic dn, input logic [RW-1:0] cnt);
        vec_t t;
        t.start = st; t.tgt = tg; t.valid = v; t.data = d; t.rdy = r;
        t.e_ar = ar; t.e_sv = sv; t.chk_dat = cd; t.e_dat = ed;
        t.e_busy = bz; t.e_done = dn; t.e_cnt = cnt;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: observe handshakes at the falling edge, advance source data after the rising edge.
    task automatic step();
        @(negedge clk);
        if (acc_valid && acc_ready) push_n++;
        if (stream_valid && stream_ready) begin
            check($sformatf("order_pop%0d", pop_n), 64'(stream_data), 64'(base + DW'(pop_n)));
            pop_n++;
        end
        if (done) done_n++;
        @(posedge clk);
        #1;
        acc_data = base + DW'(push_n);
    endtask

    task automatic new_job(input logic [RW-1:0] tgt, input logic [DW-1:0] b, input logic rdy);
        base = b; push_n = 0; pop_n = 0; done_n = 0;
        acc_data = b; acc_valid = 1'b1; stream_ready = rdy;
        beat_target = tgt; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; acc_data = '0; acc_valid = 1'b0; stream_ready = 1'b0;
        beat_target = '0; start = 1'b0; clear = 1'b0;
        push_n = 0; pop_n = 0; done_n = 0; base = '0;

        // target 3 with always-valid source and always-ready sink, then a zero-beat job
        tbl[0] = mk(1'b1, 32'd3, 1'b1, 32'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'd0);
        tbl[1] = mk(1'b0, 32'd0, 1'b1, 32'hA1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'd0);
        tbl[2] = mk(1'b1, 32'd7, 1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b1, 1'b0, 32'd0);
        tbl[3] = mk(1'b0, 32'd0, 1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA2, 1'b1, 1'b0, 32'd1);
        tbl[4] = mk(1'b0, 32'd0, 1'b1, 32'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA3, 1'b1, 1'b0, 32'd2);
        tbl[5] = mk(1'b0, 32'd0, 1'b1, 32'hA4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'd3);
        tbl[6] = mk(1'b0, 32'd0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'd3);
        tbl[7] = mk(1'b1, 32'd0, 1'b1, 32'hC1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'd3);
        tbl[8] = mk(1'b0, 32'd0, 1'b1, 32'hC1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'd0);
        tbl[9] = mk(1'b0, 32'd0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'd0);

        #12;
        check("rst_acc_ready", 64'(acc_ready), 64'd0);
        check("rst_stream_valid", 64'(stream_valid), 64'd0);
        check("rst_stream_data", 64'(stream_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_beat_count", 64'(beat_count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            start = tbl[i].start; beat_target = tbl[i].tgt; acc_valid = tbl[i].valid;
            acc_data = tbl[i].data; stream_ready = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_acc_ready", i), 64'(acc_ready), 64'(tbl[i].e_ar));
            check($sformatf("vec%0d_stream_valid", i), 64'(stream_valid), 64'(tbl[i].e_sv));
            if (tbl[i].chk_dat)
                check($sformatf("vec%0d_stream_data", i), 64'(stream_data), 64'(tbl[i].e_dat));
            check($sformatf("vec%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
            check($sformatf("vec%0d_done", i), 64'(done), 64'(tbl[i].e_done));
            check($sformatf("vec%0d_beat_count", i), 64'(beat_count), 64'(tbl[i].e_cnt));
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        // target 8 into a 4-deep FIFO with the sink stalled, then released
        new_job(32'd8, 32'hB0, 1'b0);
        repeat (7) step();
        check("bp_pushes_when_full", 64'(push_n), 64'd4);
        check("bp_acc_ready_low", 64'(acc_ready), 64'd0);
        check("bp_stream_valid", 64'(stream_valid), 64'd1);
        check("bp_head_held", 64'(stream_data), 64'hB0);
        stream_ready = 1'b1;
        for (int k = 0; k < 40 && done_n == 0; k++) step();
        repeat (2) step();
        check("bp_pops", 64'(pop_n), 64'd8);
        check("bp_done_once", 64'(done_n), 64'd1);
        check("bp_beat_count", 64'(beat_count), 64'd8);

        // simultaneous push/pop at occupancy 2 for 10 cycles, pointers wrap
        new_job(32'd12, 32'hC0, 1'b0);
        repeat (2) step();
        check("pp_prefill", 64'(push_n), 64'd2);
        stream_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("pp_occ_cycle%0d", k), 64'(push_n - pop_n), 64'd2);
        end
        check("pp_pushes", 64'(push_n), 64'd12);
        for (int k = 0; k < 20 && done_n == 0; k++) step();
        check("pp_pops", 64'(pop_n), 64'd12);
        check("pp_done_once", 64'(done_n), 64'd1);
        check("pp_beat_count", 64'(beat_count), 64'd12);

        // clear while draining with two beats buffered
        new_job(32'd2, 32'hD0, 1'b0);
        repeat (3) step();
        check("clr_pre_busy", 64'(busy), 64'd1);
        check("clr_pre_valid", 64'(stream_valid), 64'd1);
        check("clr_pre_acc_ready", 64'(acc_ready), 64'd0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_stream_valid", 64'(stream_valid), 64'd0);
        check("clr_beat_count", 64'(beat_count), 64'd0);
        check("clr_done", 64'(done), 64'd0);
        acc_valid = 1'b0; stream_ready = 1'b1;
        repeat (3) step();
        check("clr_no_done_after", 64'(done_n), 64'd0);
        check("clr_no_pops_after", 64'(pop_n), 64'd0);

        // reset pulse mid-job, then a fresh 2-beat job
        new_job(32'd5, 32'hE0, 1'b0);
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_stream_valid", 64'(stream_valid), 64'd0);
        check("mid_rst_stream_data", 64'(stream_data), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_acc_ready", 64'(acc_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        new_job(32'd2, 32'hF0, 1'b1);
        check("post_rst_start_taken", 64'(busy), 64'd1);
        for (int k = 0; k < 20 && done_n == 0; k++) step();
        check("post_rst_pops", 64'(pop_n), 64'd2);
        check("post_rst_done_once", 64'(done_n), 64'd1);
        check("post_rst_beat_count", 64'(beat_count), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
